// File: rtl/sysid_arb_pkg.sv
// Shared types and width helpers for the sysid read arbiter.
package sysid_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_t;

  // Bits needed to index 'value' distinct items, never less than one.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return (r < 1) ? 1 : r;
  endfunction

  localparam int MAX_SLAVE_LATENCY = 7;
  localparam int LAT_W             = clog2(MAX_SLAVE_LATENCY + 1);

endpackage

// File: rtl/sysid_arbiter_if.sv
// Requester-side and slave-side Avalon-MM read signals of the sysid arbiter.
interface sysid_arbiter_if #(
  parameter int NUM_REQ = 4,
  parameter int ADDR_W  = 1,
  parameter int DATA_W  = 32
);
  // Handshake: a requester raises req_read[i] with req_address and holds both
  // until a rising edge where req_waitrequest[i] is low; that edge accepts the
  // read. The result returns later as a one-cycle req_readdatavalid[i] pulse
  // with req_readdata. The slave answers combinationally without stalling.
  logic [NUM_REQ-1:0]        req_read;
  logic [NUM_REQ*ADDR_W-1:0] req_address;
  logic [NUM_REQ-1:0]        req_waitrequest;
  logic [DATA_W-1:0]         req_readdata;
  logic [NUM_REQ-1:0]        req_readdatavalid;
  logic                      slv_read;
  logic [ADDR_W-1:0]         slv_address;
  logic [DATA_W-1:0]         slv_readdata;

  modport slave (
    input  req_read, req_address, slv_readdata,
    output req_waitrequest, req_readdata, req_readdatavalid, slv_read, slv_address
  );

  modport master (
    output req_read, req_address, slv_readdata,
    input  req_waitrequest, req_readdata, req_readdatavalid, slv_read, slv_address
  );
endinterface

// File: rtl/sysid_rr_picker.sv
// Combinational round-robin first-one finder starting just after rr_ptr.
module sysid_rr_picker
  import sysid_arb_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = 2
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   rr_ptr,
  output logic [IDX_W-1:0]   grant,
  output logic               any_req
);

  always_comb begin
    logic [IDX_W-1:0] idx;
    grant   = '0;
    any_req = 1'b0;
    idx     = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      idx = IDX_W'((int'(rr_ptr) + k) % NUM_REQ);
      if (!any_req && req[idx]) begin
        any_req = 1'b1;
        grant   = idx;
      end
    end
  end

endmodule

// File: rtl/sysid_arbiter.sv
// Round-robin arbiter sharing one sysid slave between NUM_REQ read masters.
// Optional read cache enabled by defining SYSID_ARB_CACHE_EN.
module sysid_arbiter
  import sysid_arb_pkg::*;
#(
  parameter int NUM_REQ       = 4,
  parameter int ADDR_W        = 1,
  parameter int DATA_W        = 32,
  parameter int SLAVE_LATENCY = 1
) (
  input  logic           clock,
  input  logic           reset,
  sysid_arbiter_if.slave bus,
  output state_t         state_dbg
);

  localparam int               IDX_W    = clog2(NUM_REQ);
  localparam logic [LAT_W-1:0] LAT_LOAD = LAT_W'(SLAVE_LATENCY - 1);

  state_t             state;
  logic [IDX_W-1:0]   rr_ptr;
  logic [IDX_W-1:0]   grant;
  logic [IDX_W-1:0]   pick;
  logic               any_req;
  logic [ADDR_W-1:0]  pick_addr;
  logic [ADDR_W-1:0]  addr_q;
  logic               hit_q;
  logic               hit_now;
  logic [LAT_W-1:0]   lat_cnt;
  logic               slv_read_q;
  logic [DATA_W-1:0]  readdata_q;
  logic [NUM_REQ-1:0] rdv_q;
  logic [DATA_W-1:0]  wait_data;

  sysid_rr_picker #(.NUM_REQ(NUM_REQ), .IDX_W(IDX_W)) u_picker (
    .req     (bus.req_read),
    .rr_ptr  (rr_ptr),
    .grant   (pick),
    .any_req (any_req)
  );

  assign pick_addr = bus.req_address[pick*ADDR_W +: ADDR_W];

`ifdef SYSID_ARB_CACHE_EN
  logic [DATA_W-1:0]      cache_data [2**ADDR_W];
  logic [2**ADDR_W-1:0]   cache_vld;

  assign hit_now   = cache_vld[pick_addr];
  assign wait_data = hit_q ? cache_data[addr_q] : bus.slv_readdata;

  always_ff @(posedge clock) begin
    if (reset) begin
      cache_vld <= '0;
    end else if (state == WAIT && !hit_q && lat_cnt == '0) begin
      cache_vld[addr_q]  <= 1'b1;
      cache_data[addr_q] <= bus.slv_readdata;
    end
  end
`else
  assign hit_now   = 1'b0;
  assign wait_data = bus.slv_readdata;
`endif

  // Only the granted requester sees its stall released, and only in ISSUE.
  always_comb begin
    bus.req_waitrequest = '1;
    if (state == ISSUE) bus.req_waitrequest[grant] = 1'b0;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= IDLE;
      rr_ptr     <= IDX_W'(NUM_REQ - 1);
      grant      <= '0;
      addr_q     <= '0;
      hit_q      <= 1'b0;
      lat_cnt    <= '0;
      slv_read_q <= 1'b0;
      readdata_q <= '0;
      rdv_q      <= '0;
    end else begin
      case (state)
        IDLE: if (any_req) begin
          grant      <= pick;
          addr_q     <= pick_addr;
          hit_q      <= hit_now;
          slv_read_q <= !hit_now;
          state      <= ISSUE;
        end
        ISSUE: begin
          if (!bus.req_read[grant]) begin
            // Read withdrawn before acceptance: drop it, pointer untouched.
            slv_read_q <= 1'b0;
            state      <= IDLE;
          end else begin
            // A cache hit spends a single WAIT cycle reading local storage.
            lat_cnt <= hit_q ? '0 : LAT_LOAD;
            state   <= WAIT;
          end
        end
        WAIT: begin
          if (lat_cnt == '0) begin
            readdata_q <= wait_data;
            rdv_q      <= NUM_REQ'(1) << grant;
            slv_read_q <= 1'b0;
            state      <= RESP;
          end else begin
            lat_cnt <= lat_cnt - 1'b1;
          end
        end
        RESP: begin
          rdv_q  <= '0;
          rr_ptr <= grant;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.slv_read          = slv_read_q;
  assign bus.slv_address       = addr_q;
  assign bus.req_readdata      = readdata_q;
  assign bus.req_readdatavalid = rdv_q;
  assign state_dbg             = state;

endmodule

// File: tb/tb_sysid_arbiter.sv
// Directed plus random bench for sysid_arbiter with a transaction-level model.
module tb_sysid_arbiter;
  import sysid_arb_pkg::*;

  localparam int NR = 4;
  localparam int AW = 1;
  localparam int DW = 32;
`ifdef SYSID_ARB_CACHE_EN
  localparam int SL    = 5;
  localparam bit CACHE = 1'b1;
`else
  localparam int SL    = 3;
  localparam bit CACHE = 1'b0;
`endif

  logic   clock = 1'b0;
  logic   reset = 1'b1;
  state_t state_dbg;
  int     checks = 0;
  int     errors = 0;

  logic [DW-1:0]    exp_q[$];
  int               m_rr;
  bit [2**AW-1:0]   m_cvld;
  bit [NR-1:0]      hold;
  bit               mid_rand;

  sysid_arbiter_if #(.NUM_REQ(NR), .ADDR_W(AW), .DATA_W(DW)) bus ();

  sysid_arbiter #(
    .NUM_REQ(NR), .ADDR_W(AW), .DATA_W(DW), .SLAVE_LATENCY(SL)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .bus       (bus),
    .state_dbg (state_dbg)
  );

  always #5 clock = ~clock;

  function automatic logic [DW-1:0] slave_word(input logic [AW-1:0] a);
    return (a == AW'(1)) ? 32'h52FD_0CB6 : 32'h0000_0000;
  endfunction

  always_comb bus.slv_readdata = slave_word(bus.slv_address);

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_req(input int i, input logic [AW-1:0] a);
    bus.req_read[i] = 1'b1;
    bus.req_address[i*AW +: AW] = a;
  endtask

  task automatic raise_random();
    for (int i = 0; i < NR; i++)
      if (!bus.req_read[i] && $urandom_range(0, 2) == 0)
        set_req(i, AW'($urandom_range(0, 2**AW - 1)));
  endtask

  // Reference arbitration: first requester after the last one served.
  function automatic int model_pick();
    for (int k = 1; k <= NR; k++) begin
      int i;
      i = (m_rr + k) % NR;
      if (bus.req_read[i]) return i;
    end
    return 0;
  endfunction

  task automatic do_reset();
    reset = 1'b1;
    bus.req_read = '0;
    tick();
    chk("rst_state", state_dbg, IDLE);
    chk("rst_waitreq", bus.req_waitrequest, {NR{1'b1}});
    chk("rst_rdv", bus.req_readdatavalid, '0);
    chk("rst_slv_read", bus.slv_read, 1'b0);
    chk("rst_slv_addr", bus.slv_address, '0);
    chk("rst_readdata", bus.req_readdata, '0);
    reset  = 1'b0;
    m_rr   = NR - 1;
    m_cvld = '0;
    hold   = '0;
  endtask

  // One full read starting from an IDLE cycle with at least one request up.
  task automatic run_txn();
    int            g;
    int            lat;
    bit            hit;
    logic [AW-1:0] a;
    logic [DW-1:0] exp_d;
    logic [NR-1:0] one;
    logic [NR-1:0] exp_wr;
    chk("idle_state", state_dbg, IDLE);
    g      = model_pick();
    a      = bus.req_address[g*AW +: AW];
    hit    = CACHE && m_cvld[a];
    lat    = hit ? 3 : 2 + SL;
    one    = NR'(1) << g;
    exp_wr = ~one;
    exp_q.push_back(slave_word(a));
    tick();
    chk("issue_waitreq", bus.req_waitrequest, exp_wr);
    chk("issue_slv_read", bus.slv_read, !hit);
    if (!hit) chk("issue_slv_addr", bus.slv_address, a);
    bus.req_address[g*AW +: AW] = ~a;
    tick();
    if (!hold[g]) bus.req_read[g] = 1'b0;
    if (mid_rand) raise_random();
    for (int c = 2; c < lat; c++) begin
      chk("busy_outputs", {bus.req_readdatavalid, bus.req_waitrequest},
          {{NR{1'b0}}, {NR{1'b1}}});
      chk("busy_slv_read", bus.slv_read, !hit);
      tick();
    end
    exp_d = exp_q.pop_front();
    chk("resp_valid", bus.req_readdatavalid, one);
    chk("resp_data", bus.req_readdata, exp_d);
    chk("resp_slv_read", bus.slv_read, 1'b0);
    m_rr      = g;
    m_cvld[a] = 1'b1;
    tick();
    chk("idle_hold_data", bus.req_readdata, exp_d);
    chk("idle_no_valid", bus.req_readdatavalid, '0);
  endtask

  initial begin
    bus.req_read    = '0;
    bus.req_address = '0;
    hold            = '0;
    mid_rand        = 1'b0;
    m_rr            = NR - 1;
    m_cvld          = '0;

    do_reset();

    // Single read of the timestamp word by requester 0.
    set_req(0, 1'b1);
    run_txn();

    // All requesters at once after reset: served 0,1,2,3.
    do_reset();
    for (int i = 0; i < NR; i++) set_req(i, AW'(i % 2));
    for (int i = 0; i < NR; i++) run_txn();

    // Requester 2 holds read continuously while 0 and 3 keep re-requesting.
    set_req(0, 1'b1);
    set_req(2, 1'b0);
    set_req(3, 1'b1);
    hold[2] = 1'b1;
    for (int n = 0; n < 6; n++) begin
      run_txn();
      if (!bus.req_read[0]) set_req(0, 1'b1);
      if (!bus.req_read[3]) set_req(3, 1'b0);
    end
    hold         = '0;
    bus.req_read = '0;

    // Reset while the read is waiting on the slave.
    set_req(2, 1'b1);
    tick();
    chk("rw_issue_waitreq", bus.req_waitrequest, 4'b1011);
    tick();
    bus.req_read[2] = 1'b0;
    chk("rw_in_wait", state_dbg, WAIT);
    do_reset();
    for (int n = 0; n < SL + 2; n++) begin
      chk("rw_no_valid", bus.req_readdatavalid, '0);
      tick();
    end
    set_req(3, 1'b1);
    set_req(0, 1'b0);
    run_txn();
    run_txn();

    // Requester withdraws read during ISSUE.
    set_req(1, 1'b1);
    tick();
    chk("abort_waitreq", bus.req_waitrequest, 4'b1101);
    bus.req_read[1] = 1'b0;
    tick();
    chk("abort_idle", state_dbg, IDLE);
    chk("abort_slv_read", bus.slv_read, 1'b0);
    for (int n = 0; n < SL + 2; n++) begin
      chk("abort_no_valid", bus.req_readdatavalid, '0);
      tick();
    end
    for (int i = 0; i < NR; i++) set_req(i, AW'($urandom_range(0, 1)));
    for (int i = 0; i < NR; i++) run_txn();

    // Repeated read of one address (cache hit path when enabled).
    do_reset();
    set_req(1, 1'b1);
    run_txn();
    set_req(1, 1'b1);
    run_txn();

    // Random traffic, including requests raised mid-transaction.
    mid_rand = 1'b1;
    repeat (60) begin
      raise_random();
      if (bus.req_read == '0) set_req($urandom_range(0, NR - 1), AW'($urandom_range(0, 1)));
      run_txn();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
